operand_queue_array: RTL and testbench

// - Parametrised bank of NrQueues operand FIFOs between the VRF operand requester and the lane's VFUs.
// - Credit-based admission: the requester may issue a VRF read only if a slot is reserved for the returning data.
// - Per-queue beat counting from a command (drives operand_last_o), per-queue flush with in-flight drop, sticky overflow error.
// - No type conversion: the raw 64-bit elen_t word passes through.

---
 rtl/operand_queue_array_pkg.sv | 22 ++
 rtl/operand_queue_array_credit_fifo.sv | 151 +++++++++++++++
 rtl/operand_queue_array.sv | 56 +++++
 tb/tb_operand_queue_array.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_queue_array_pkg.sv
// Shared types and defaults for the lane operand queues.
// Holds the element type, the command descriptor and the default per-queue depths.
package ara_pkg;

  localparam int unsigned ELEN = 64;
  typedef logic [ELEN-1:0] elen_t;

  localparam int unsigned OpCntWidth = 16;
  typedef struct packed {
    logic [OpCntWidth-1:0] beats;
  } operand_queue_cnt_cmd_t;

  localparam int unsigned DefaultNrQueues = 8;
  localparam int unsigned DefaultMaxDepth = 5;
  localparam int unsigned DefaultQueueDepth [DefaultNrQueues] = '{5, 5, 5, 5, 5, 2, 2, 1};

  // Bits needed to index n distinct values; never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_queue_array_credit_fifo.sv
// One operand queue: credit-reserved FIFO, flush/drop bookkeeping and command beat counter.
// Head data is visible the cycle after it is pushed; pointers wrap at Depth.
module operand_credit_fifo
  import ara_pkg::*;
#(
  parameter int unsigned Depth    = 5,
  parameter int unsigned MaxDepth = 5,
  parameter int unsigned CntWidth = OpCntWidth,
  parameter int unsigned OccW     = idx_width(MaxDepth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [CntWidth-1:0] cmd_beats_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                operand_issued_i,
  output logic                operand_queue_ready_o,
  input  elen_t               operand_i,
  input  logic                operand_valid_i,
  output elen_t               operand_o,
  output logic                operand_valid_o,
  input  logic                operand_ready_i,
  output logic                operand_last_o,
  output logic [OccW-1:0]     occupancy_o,
  output logic                overflow_o
);

  localparam int unsigned PtrW  = idx_width(Depth);
  localparam int unsigned DropW = OccW + 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  elen_t               mem_q [Depth];
  logic [PtrW-1:0]     rd_ptr_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [OccW-1:0]     occ_q;
  logic [OccW-1:0]     inflight_q;
  logic [DropW-1:0]    drop_q;
  logic                active_q;
  logic [CntWidth-1:0] beats_q;
  logic [CntWidth-1:0] beat_cnt_q;
  logic                overflow_q;

  logic                issue;
  logic                push;
  logic                pop;
  logic                last;
  logic                cmd_fire;
  logic [OccW:0]       credit_used;
  logic [DropW-1:0]    drop_total;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Credits count both stored words and reads still on their way back.
  assign credit_used           = {1'b0, occ_q} + {1'b0, inflight_q};
  assign operand_queue_ready_o = credit_used < (OccW + 1)'(Depth);
  assign issue                 = operand_issued_i & operand_queue_ready_o;

  assign operand_valid_o = active_q & (occ_q != '0);
  assign last            = operand_valid_o & (beat_cnt_q == beats_q - CntWidth'(1));
  assign operand_last_o  = last;
  assign pop             = operand_valid_o & operand_ready_i;
  assign operand_o       = operand_valid_o ? mem_q[rd_ptr_q] : '0;

  assign cmd_ready_o = !active_q | (pop & last);
  assign cmd_fire    = cmd_valid_i & cmd_ready_o;

  // Data is only kept when it answers a live reservation and nothing is owed to a flush.
  assign push       = operand_valid_i & !flush_i & (drop_q == '0) & (inflight_q != '0);
  assign drop_total = drop_q + DropW'(inflight_q) + DropW'(issue);

  assign occupancy_o = occ_q;
  assign overflow_o  = overflow_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= operand_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      active_q   <= 1'b0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      active_q   <= 1'b0;
      beat_cnt_q <= '0;
      // A word arriving in the flush cycle already belongs to the discarded reads.
      if (operand_valid_i && drop_total == '0) begin
        overflow_q <= 1'b1;
        drop_q     <= '0;
      end else begin
        drop_q <= drop_total - DropW'(operand_valid_i);
      end
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      occ_q      <= occ_q + OccW'(push) - OccW'(pop);
      inflight_q <= inflight_q + OccW'(issue) - OccW'(push);

      if (operand_valid_i) begin
        if (drop_q != '0) begin
          drop_q <= drop_q - DropW'(1);
        end else if (inflight_q == '0) begin
          overflow_q <= 1'b1;
        end
      end

      if (pop) begin
        beat_cnt_q <= beat_cnt_q + CntWidth'(1);
        if (last) begin
          active_q <= 1'b0;
        end
      end

      // A zero-beat command retires on acceptance and never becomes active.
      if (cmd_fire) begin
        beats_q    <= cmd_beats_i;
        beat_cnt_q <= '0;
        active_q   <= (cmd_beats_i != '0);
      end
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(operand_issued_i && !operand_queue_ready_o));
      assert (!(issue && inflight_q == '1));
      assert (!(flush_i && drop_total < drop_q));
      assert (!(push && !pop && occ_q == OccW'(Depth)));
    end
  end

endmodule

// File: rtl/operand_queue_array.sv
// Bank of independent credit-based operand queues between the VRF requester and the VFUs.
// Each lane slot gets its own depth; data passes through untouched.
module operand_queue_array
  import ara_pkg::*;
#(
  parameter  int unsigned NrQueues               = DefaultNrQueues,
  parameter  int unsigned MaxDepth               = DefaultMaxDepth,
  parameter  int unsigned QueueDepth [NrQueues]  = DefaultQueueDepth,
  parameter  int unsigned CntWidth               = OpCntWidth,
  localparam int unsigned OccW                   = idx_width(MaxDepth + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NrQueues-1:0]          flush_i,
  input  logic [NrQueues*CntWidth-1:0] cmd_i,
  input  logic [NrQueues-1:0]          cmd_valid_i,
  output logic [NrQueues-1:0]          cmd_ready_o,
  input  logic [NrQueues-1:0]          operand_issued_i,
  output logic [NrQueues-1:0]          operand_queue_ready_o,
  input  logic [NrQueues*ELEN-1:0]     operand_i,
  input  logic [NrQueues-1:0]          operand_valid_i,
  output logic [NrQueues*ELEN-1:0]     operand_o,
  output logic [NrQueues-1:0]          operand_valid_o,
  input  logic [NrQueues-1:0]          operand_ready_i,
  output logic [NrQueues-1:0]          operand_last_o,
  output logic [NrQueues*OccW-1:0]     occupancy_o,
  output logic [NrQueues-1:0]          overflow_o
);

  for (genvar gi = 0; gi < NrQueues; gi++) begin : gen_queue
    operand_credit_fifo #(
      .Depth    (QueueDepth[gi]),
      .MaxDepth (MaxDepth),
      .CntWidth (CntWidth),
      .OccW     (OccW)
    ) i_queue (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .flush_i               (flush_i[gi]),
      .cmd_beats_i           (cmd_i[gi*CntWidth +: CntWidth]),
      .cmd_valid_i           (cmd_valid_i[gi]),
      .cmd_ready_o           (cmd_ready_o[gi]),
      .operand_issued_i      (operand_issued_i[gi]),
      .operand_queue_ready_o (operand_queue_ready_o[gi]),
      .operand_i             (operand_i[gi*ELEN +: ELEN]),
      .operand_valid_i       (operand_valid_i[gi]),
      .operand_o             (operand_o[gi*ELEN +: ELEN]),
      .operand_valid_o       (operand_valid_o[gi]),
      .operand_ready_i       (operand_ready_i[gi]),
      .operand_last_o        (operand_last_o[gi]),
      .occupancy_o           (occupancy_o[gi*OccW +: OccW]),
      .overflow_o            (overflow_o[gi])
    );
  end

endmodule

// File: tb/tb_operand_queue_array.sv
// Bench for operand_queue_array: directed scenarios plus random 8-queue traffic,
// checked every cycle against a queue-level model of the credit/flush/command rules.
module tb_operand_queue_array;
  import ara_pkg::*;

  localparam int NQ = 8;
  localparam int CW = 16;
  localparam int OW = 3;
  localparam int DEP [NQ] = '{5, 5, 5, 5, 5, 2, 2, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NQ-1:0]    flush, cmd_valid, cmd_ready, issued, q_ready;
  logic [NQ-1:0]    vin, vout, rdy, last, ovf;
  logic [NQ*CW-1:0] cmd;
  logic [NQ*64-1:0] din, dout;
  logic [NQ*OW-1:0] occ;

  always #5 clk = ~clk;

  operand_queue_array dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush),
    .cmd_i                 (cmd),
    .cmd_valid_i           (cmd_valid),
    .cmd_ready_o           (cmd_ready),
    .operand_issued_i      (issued),
    .operand_queue_ready_o (q_ready),
    .operand_i             (din),
    .operand_valid_i       (vin),
    .operand_o             (dout),
    .operand_valid_o       (vout),
    .operand_ready_i       (rdy),
    .operand_last_o        (last),
    .occupancy_o           (occ),
    .overflow_o            (ovf)
  );

  // Behavioural model state
  logic [63:0] mq [NQ][$];
  int m_inflight [NQ];
  int m_drop     [NQ];
  int m_beats    [NQ];
  int m_idx      [NQ];
  bit m_active   [NQ];
  bit m_ovf      [NQ];
  int pending    [NQ];
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  function automatic bit e_ready(int q);
    return (mq[q].size() + m_inflight[q]) < DEP[q];
  endfunction
  function automatic bit e_valid(int q);
    return m_active[q] && (mq[q].size() > 0);
  endfunction
  function automatic bit e_last(int q);
    return e_valid(q) && (m_idx[q] == m_beats[q] - 1);
  endfunction
  function automatic bit e_cmd_ready(int q);
    return !m_active[q] || (e_valid(q) && rdy[q] && e_last(q));
  endfunction
  function automatic logic [63:0] e_data(int q);
    return e_valid(q) ? mq[q][0] : 64'd0;
  endfunction

  function automatic void model_reset();
    for (int q = 0; q < NQ; q++) begin
      mq[q].delete();
      m_inflight[q] = 0; m_drop[q] = 0; m_beats[q] = 0; m_idx[q] = 0;
      m_active[q] = 1'b0; m_ovf[q] = 1'b0;
    end
  endfunction

  function automatic void model_step(int q);
    bit p, l, cr, iss;
    int tot;
    p   = e_valid(q) && rdy[q];
    l   = e_last(q);
    cr  = e_cmd_ready(q);
    iss = issued[q] && e_ready(q);
    if (flush[q]) begin
      tot = m_drop[q] + m_inflight[q] + int'(iss);
      if (vin[q]) begin
        if (tot == 0) m_ovf[q] = 1'b1;
        else tot--;
      end
      m_drop[q] = tot; m_inflight[q] = 0; mq[q].delete();
      m_active[q] = 1'b0; m_idx[q] = 0;
    end else begin
      if (p) begin
        void'(mq[q].pop_front());
        m_idx[q]++;
        if (l) m_active[q] = 1'b0;
      end
      if (vin[q]) begin
        if (m_drop[q] > 0) m_drop[q]--;
        else if (m_inflight[q] > 0) begin
          mq[q].push_back(din[q*64 +: 64]);
          m_inflight[q]--;
        end else m_ovf[q] = 1'b1;
      end
      if (iss) m_inflight[q]++;
      if (cmd_valid[q] && cr) begin
        m_beats[q]  = int'(cmd[q*CW +: CW]);
        m_idx[q]    = 0;
        m_active[q] = (m_beats[q] != 0);
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int q = 0; q < NQ; q++) model_step(q);
  end

  task automatic check(input string name, input int q, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s q%0d: got %h want %h @%0t", name, q, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      for (int q = 0; q < NQ; q++) begin
        check("q_ready",   q, 64'(q_ready[q]),        64'(e_ready(q)));
        check("valid_o",   q, 64'(vout[q]),           64'(e_valid(q)));
        check("last_o",    q, 64'(last[q]),           64'(e_last(q)));
        check("data_o",    q, dout[q*64 +: 64],       e_data(q));
        check("cmd_ready", q, 64'(cmd_ready[q]),      64'(e_cmd_ready(q)));
        check("occupancy", q, 64'(occ[q*OW +: OW]),   64'(mq[q].size()));
        check("overflow",  q, 64'(ovf[q]),            64'(m_ovf[q]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = '0; cmd_valid = '0; issued = '0; vin = '0; rdy = '0;
  endtask

  task automatic check_reset_values(input string tag);
    for (int q = 0; q < NQ; q++) begin
      check({tag, "_qready"}, q, 64'(q_ready[q]),      64'd1);
      check({tag, "_cready"}, q, 64'(cmd_ready[q]),    64'd1);
      check({tag, "_valid"},  q, 64'(vout[q]),         64'd0);
      check({tag, "_last"},   q, 64'(last[q]),         64'd0);
      check({tag, "_occ"},    q, 64'(occ[q*OW +: OW]), 64'd0);
      check({tag, "_ovf"},    q, 64'(ovf[q]),          64'd0);
      check({tag, "_data"},   q, dout[q*64 +: 64],     64'd0);
    end
  endtask

  initial begin
    idle();
    cmd = '0;
    din = '0;
    for (int q = 0; q < NQ; q++) pending[q] = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    check_reset_values("rst");

    // 1: fill depth-5 queue 0 through credits, then free one slot
    cmd[0 +: CW] = 16'd5; cmd_valid[0] = 1'b1; tick(); cmd_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin issued[0] = 1'b1; tick(); end
    issued[0] = 1'b0;
    check("t1_ready_low", 0, 64'(q_ready[0]), 64'd0);
    for (int i = 0; i < 5; i++) begin vin[0] = 1'b1; din[0 +: 64] = 64'h1000 + 64'(i); tick(); end
    vin[0] = 1'b0;
    check("t1_occ5", 0, 64'(occ[0 +: OW]), 64'd5);
    check("t1_head", 0, dout[0 +: 64], 64'h1000);
    rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
    check("t1_ready_back", 0, 64'(q_ready[0]), 64'd1);
    check("t1_occ4", 0, 64'(occ[0 +: OW]), 64'd4);
    rdy[0] = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("t1_drain_head", 0, dout[0 +: 64], 64'h1000 + 64'(i));
      check("t1_drain_last", 0, 64'(last[0]), (i == 4) ? 64'd1 : 64'd0);
      tick();
    end
    rdy[0] = 1'b0;

    // 2: three-beat command on queue 1
    cmd[CW +: CW] = 16'd3; cmd_valid[1] = 1'b1;
    check("t2_cready_idle", 1, 64'(cmd_ready[1]), 64'd1);
    tick(); cmd_valid[1] = 1'b0;
    check("t2_cready_busy", 1, 64'(cmd_ready[1]), 64'd0);
    for (int i = 0; i < 3; i++) begin issued[1] = 1'b1; tick(); end
    issued[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin vin[1] = 1'b1; din[64 +: 64] = 64'hA0 + 64'(i); tick(); end
    vin[1] = 1'b0;
    check("t2_headA", 1, dout[64 +: 64], 64'hA0);
    check("t2_lastA", 1, 64'(last[1]), 64'd0);
    rdy[1] = 1'b1; tick();
    check("t2_headB", 1, dout[64 +: 64], 64'hA1);
    check("t2_lastB", 1, 64'(last[1]), 64'd0);
    tick();
    check("t2_headC", 1, dout[64 +: 64], 64'hA2);
    check("t2_lastC", 1, 64'(last[1]), 64'd1);
    check("t2_cready_popC", 1, 64'(cmd_ready[1]), 64'd1);
    tick(); rdy[1] = 1'b0;
    check("t2_done", 1, 64'(vout[1]), 64'd0);

    // 3: depth-2 queue 5 with simultaneous push/pop/issue
    cmd[5*CW +: CW] = 16'd4; cmd_valid[5] = 1'b1; tick(); cmd_valid[5] = 1'b0;
    issued[5] = 1'b1; tick(); tick(); issued[5] = 1'b0;
    check("t3_full_credit", 5, 64'(q_ready[5]), 64'd0);
    vin[5] = 1'b1; din[320 +: 64] = 64'hB0; tick();
    check("t3_occ1", 5, 64'(occ[15 +: OW]), 64'd1);
    din[320 +: 64] = 64'hB1; rdy[5] = 1'b1; tick();
    check("t3_pushpop_occ", 5, 64'(occ[15 +: OW]), 64'd1);
    check("t3_pushpop_head", 5, dout[320 +: 64], 64'hB1);
    vin[5] = 1'b0; issued[5] = 1'b1; tick();
    check("t3_issuepop_occ", 5, 64'(occ[15 +: OW]), 64'd0);
    rdy[5] = 1'b0; vin[5] = 1'b1; din[320 +: 64] = 64'hB2; tick();
    check("t3_issuepush_ready", 5, 64'(q_ready[5]), 64'd0);
    check("t3_issuepush_head", 5, dout[320 +: 64], 64'hB2);
    issued[5] = 1'b0; din[320 +: 64] = 64'hB3; rdy[5] = 1'b1; tick();
    check("t3_head_last", 5, dout[320 +: 64], 64'hB3);
    check("t3_last", 5, 64'(last[5]), 64'd1);
    vin[5] = 1'b0; tick(); rdy[5] = 1'b0;
    check("t3_empty", 5, 64'(occ[15 +: OW]), 64'd0);

    // 4: flush with two reads in flight plus one issued in the flush cycle
    issued[2] = 1'b1; tick(); tick();
    flush[2] = 1'b1; tick(); flush[2] = 1'b0; issued[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin vin[2] = 1'b1; din[128 +: 64] = 64'hC0 + 64'(i); tick(); end
    vin[2] = 1'b0;
    check("t4_occ0", 2, 64'(occ[6 +: OW]), 64'd0);
    check("t4_no_ovf", 2, 64'(ovf[2]), 64'd0);
    vin[2] = 1'b1; tick(); vin[2] = 1'b0;
    check("t4_ovf", 2, 64'(ovf[2]), 64'd1);

    // 5: zero-beat command retires immediately on queue 3
    cmd[3*CW +: CW] = 16'd0; cmd_valid[3] = 1'b1;
    check("t5_cready0", 3, 64'(cmd_ready[3]), 64'd1);
    tick();
    check("t5_no_valid", 3, 64'(vout[3]), 64'd0);
    cmd[3*CW +: CW] = 16'd2;
    check("t5_cready_next", 3, 64'(cmd_ready[3]), 64'd1);
    tick(); cmd_valid[3] = 1'b0;
    check("t5_busy", 3, 64'(cmd_ready[3]), 64'd0);

    // 6: asynchronous reset with queue 4 half full mid-command
    cmd[4*CW +: CW] = 16'd4; cmd_valid[4] = 1'b1; tick(); cmd_valid[4] = 1'b0;
    issued[4] = 1'b1; tick(); tick(); tick(); issued[4] = 1'b0;
    vin[4] = 1'b1; din[256 +: 64] = 64'hD0; tick(); din[256 +: 64] = 64'hD1; tick(); vin[4] = 1'b0;
    check("t6_occ2", 4, 64'(occ[12 +: OW]), 64'd2);
    check("t6_valid", 4, 64'(vout[4]), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("arst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Random concurrent traffic on all queues; the VRF side returns every issued read.
    for (int c = 0; c < 3000; c++) begin
      idle();
      for (int q = 0; q < NQ; q++) begin
        if (pending[q] > 0 && $urandom_range(0, 1) == 1) begin
          vin[q] = 1'b1;
          din[q*64 +: 64] = {$urandom, $urandom};
          pending[q]--;
        end
        if ($urandom_range(0, 49) == 0) flush[q] = 1'b1;
        if (e_ready(q) && $urandom_range(0, 9) < 6) begin
          issued[q] = 1'b1;
          pending[q]++;
        end
        rdy[q] = ($urandom_range(0, 9) < 7);
        if (!flush[q] && $urandom_range(0, 9) < 3) begin
          cmd_valid[q] = 1'b1;
          cmd[q*CW +: CW] = 16'($urandom_range(0, 4));
        end
      end
      tick();
    end
    idle();
    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
